// File: rtl/bf_stdout_uart.sv
// rtl/bf_stdout_uart.sv - brainfuck stdout sink: byte FIFO feeding a UART 8N1 transmitter
// Define BF_UART_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module bf_stdout_uart #(
    parameter int CLKS_PER_BIT    = 104,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               stdout,
    input  logic                     stdout_en,
    output logic                     tx,
    output logic                     busy,
    output logic                     fifo_full,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count,
    output logic                     overflow
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int BW    = $clog2(CLKS_PER_BIT);
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;

    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE    = BW'(1);
    localparam logic [CW-1:0] DEPTH_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE = FIFO_DEPTH_LOG2'(1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
`ifdef BF_UART_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
`endif

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]              count;
    logic                       en_q;
    logic [2:0]                 state;
    logic [BW-1:0]              baud;
    logic [7:0]                 shreg;
    logic [2:0]                 bit_idx;
    logic [7:0]                 rd_data;
    logic                       push;
    logic                       pop;
    logic                       full;
    logic                       wr_en;
`ifdef BF_UART_PARITY_EN
    logic                       parity_bit;
`endif

    // Edge-detect the strobe: proc may hold stdout_en high while stalled.
    assign push    = stdout_en & ~en_q;
    assign pop     = (state == IDLE) && (count != '0);
    assign full    = (count == DEPTH_CNT);
    assign wr_en   = push & (~full | pop);
    assign rd_data = mem[rd_ptr];

    assign fifo_count = count;
    assign fifo_full  = full;
    assign busy       = (state != IDLE) | (count != '0);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= stdout;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            en_q <= stdout_en;
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            baud    <= '0;
            shreg   <= '0;
            bit_idx <= '0;
`ifdef BF_UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shreg <= rd_data;
                        tx    <= 1'b0;
                        baud  <= BAUD_RELOAD;
                        state <= START;
`ifdef BF_UART_PARITY_EN
                        parity_bit <= ^rd_data;
`endif
                    end
                end
                START, DATA, STOP
`ifdef BF_UART_PARITY_EN
                , PARITY
`endif
                : begin
                    if (baud != '0) begin
                        baud <= baud - BAUD_ONE;
                    end else begin
                        baud <= BAUD_RELOAD;
                        case (state)
                            START: begin
                                tx      <= shreg[0];
                                bit_idx <= '0;
                                state   <= DATA;
                            end
                            DATA: begin
                                if (bit_idx == 3'd7) begin
`ifdef BF_UART_PARITY_EN
                                    tx    <= parity_bit;
                                    state <= PARITY;
`else
                                    tx    <= 1'b1;
                                    state <= STOP;
`endif
                                end else begin
                                    shreg   <= {1'b0, shreg[7:1]};
                                    tx      <= shreg[1];
                                    bit_idx <= bit_idx + 3'd1;
                                end
                            end
`ifdef BF_UART_PARITY_EN
                            PARITY: begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
`endif
                            default: begin
                                tx    <= 1'b1;
                                state <= IDLE;
                            end
                        endcase
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bf_stdout_uart.sv
// tb/tb_bf_stdout_uart.sv - self-checking bench for bf_stdout_uart (CLKS_PER_BIT=4, depth 4)
// Honours BF_UART_PARITY_EN for the 8E1 frame variant.
module tb_bf_stdout_uart;
    localparam int CPB   = 4;
    localparam int LOG2  = 2;
    localparam int DEPTH = 4;
`ifdef BF_UART_PARITY_EN
    localparam int FRAME = 11 * CPB;
`else
    localparam int FRAME = 10 * CPB;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] stdout;
    logic       stdout_en;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic [2:0] fifo_count;
    logic       overflow;

    bf_stdout_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(LOG2)) dut (
        .clk(clk), .reset(reset), .stdout(stdout), .stdout_en(stdout_en),
        .tx(tx), .busy(busy), .fifo_full(fifo_full), .fifo_count(fifo_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: queue of accepted bytes, transmitter modelled as busy for whole frames.
    logic [7:0] mq[$];
    int         c = 0;
    int         next_pop = 0;
    bit         has_frame = 0;
    int         cur_start = 0;
    logic [7:0] cur_byte = 8'h00;
    bit         m_ovf = 0;
    bit         m_prev_en = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, c, got, exp);
        end
    endtask

    function automatic logic line_bit(input logic [7:0] d, input int idx);
`ifdef BF_UART_PARITY_EN
        logic [10:0] l;
        l = {1'b1, ^d, d, 1'b0};
`else
        logic [9:0] l;
        l = {1'b1, d, 1'b0};
`endif
        return l[idx];
    endfunction

    function automatic logic exp_tx();
        int k;
        k = c - 1;
        if (has_frame && k >= cur_start && k < cur_start + FRAME)
            return line_bit(cur_byte, (k - cur_start) / CPB);
        return 1'b1;
    endfunction

    function automatic logic exp_busy();
        return (has_frame && (c - 1) < cur_start + FRAME) || (mq.size() != 0);
    endfunction

    task automatic model_reset();
        mq.delete();
        has_frame = 0;
        next_pop  = 0;
        m_ovf     = 0;
        m_prev_en = 0;
    endtask

    task automatic model_step(input logic en, input logic [7:0] d);
        bit do_push;
        do_push = en && !m_prev_en;
        if (mq.size() > 0 && c >= next_pop) begin
            cur_byte  = mq.pop_front();
            cur_start = c;
            has_frame = 1;
            next_pop  = c + FRAME + 1;
        end
        if (do_push) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else m_ovf = 1;
        end
        m_prev_en = en;
        c++;
    endtask

    task automatic tick(input logic en, input logic [7:0] d);
        logic [6:0] got;
        logic [6:0] exp;
        stdout_en = en;
        stdout    = d;
        model_step(en, d);
        @(negedge clk);
        exp = {exp_tx(), exp_busy(), mq.size() == DEPTH, m_ovf, 3'(mq.size())};
        got = {tx, busy, fifo_full, overflow, fifo_count};
        check("tick", 32'(got), 32'(exp));
    endtask

    task automatic do_reset();
        stdout_en = 1'b0;
        #1 reset = 1'b1;
        #1 check("rst_async", 32'({tx, busy, fifo_full, overflow, fifo_count}), 32'b1000000);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain(input string name, input int bound);
        int g;
        g = 0;
        while (busy && g < bound) begin
            tick(1'b0, 8'h00);
            g++;
        end
        check(name, 32'(g < bound), 32'd1);
    endtask

    typedef struct {
        logic [7:0] data;
        int         hold;
        int         exp_peak;
        logic       exp_par;
    } vec_t;

    vec_t vt[6];
    int   r_peak;
    int   r_busy;
    logic r_par;

    task automatic record(input int t0);
        if (int'(fifo_count) > r_peak) r_peak = int'(fifo_count);
        if (busy) r_busy++;
        if (c - 1 == t0 + 1 + 9 * CPB + CPB / 2) r_par = tx;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        stdout_en = 1'b0;
        stdout    = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_state", 32'({tx, busy, fifo_full, overflow, fifo_count}), 32'b1000000);
        reset = 1'b0;
        model_reset();

        vt[0] = '{8'h41, 1,  1, 1'b0};
        vt[1] = '{8'h55, 10, 1, 1'b0};
        vt[2] = '{8'h43, 1,  1, 1'b1};
        vt[3] = '{8'h00, 3,  1, 1'b0};
        vt[4] = '{8'hFF, 1,  1, 1'b0};
        vt[5] = '{8'h80, 2,  1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            int t0;
            int g;
            t0 = c;
            r_peak = 0;
            r_busy = 0;
            r_par  = 1'bx;
            for (int h = 0; h < vt[i].hold; h++) begin
                tick(1'b1, vt[i].data);
                record(t0);
            end
            g = 0;
            while (busy && g < 300) begin
                tick(1'b0, 8'h00);
                record(t0);
                g++;
            end
            check("vec_drain", 32'(g < 300), 32'd1);
            check("vec_peak", 32'(r_peak), 32'(vt[i].exp_peak));
            check("vec_busy_len", 32'(r_busy), 32'(FRAME + 1));
`ifdef BF_UART_PARITY_EN
            check("vec_parity", 32'(r_par), 32'(vt[i].exp_par));
`endif
        end

        // Six strobes four clocks apart: four queue, the sixth is dropped.
        do_reset();
        for (int v = 1; v <= 6; v++) begin
            tick(1'b1, 8'(v));
            repeat (3) tick(1'b0, 8'h00);
        end
        check("burst_count", 32'(fifo_count), 32'd4);
        check("burst_full", 32'(fifo_full), 32'd1);
        check("burst_ovf", 32'(overflow), 32'd1);
        drain("burst_drain", 600);

        // Reset while data bit 3 of 0x41 (a zero) is on the line.
        do_reset();
        tick(1'b1, 8'h41);
        repeat (18) tick(1'b0, 8'h00);
        check("midframe_tx_low", 32'(tx), 32'd0);
        do_reset();
        repeat (20) tick(1'b0, 8'h00);

        // Strobe lands on the pop cycle with the FIFO full.
        do_reset();
        for (int k = 0; k < 42; k++) tick((k <= 8) && (k % 2 == 0), 8'(8'h10 + k));
        check("pre_pop_full", 32'(fifo_count), 32'd4);
        tick(1'b1, 8'hA5);
        check("pop_push_count", 32'(fifo_count), 32'd4);
        check("pop_push_ovf", 32'(overflow), 32'd0);
        drain("pop_push_drain", 600);

        // Randomised traffic: sparse strobes first, then dense ones that overflow.
        do_reset();
        for (int k = 0; k < 800; k++)
            tick($urandom_range(0, 29) == 0, 8'($urandom));
        for (int k = 0; k < 800; k++)
            tick($urandom_range(0, 2) == 0, 8'($urandom));
        drain("rand_drain", 1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
